// File: rtl/mmio_pkg.sv
// Shared constants and helpers for the data-side memory responder.
// Register offsets, TCON bit positions and region decode.
package mmio_pkg;

   localparam logic [4:0] OFF_TH      = 5'h00;
   localparam logic [4:0] OFF_TL      = 5'h04;
   localparam logic [4:0] OFF_TCON    = 5'h08;
   localparam logic [4:0] OFF_LED     = 5'h0C;
   localparam logic [4:0] OFF_SWITCH  = 5'h10;
   localparam logic [4:0] OFF_SYSTICK = 5'h14;

   localparam logic [31:0] MMIO_SPAN = 32'h18;

   localparam int TCON_EN = 0;
   localparam int TCON_IE = 1;
   localparam int TCON_IS = 2;

   typedef enum logic [1:0] {
      REGION_NONE,
      REGION_RAM,
      REGION_MMIO
   } region_e;

   function automatic region_e decode_region(
      input logic [31:0] addr,
      input logic [31:0] ram_bytes,
      input logic [31:0] base
   );
      logic [31:0] off;
      off = addr - base;
      if (addr < ram_bytes)
         return REGION_RAM;
      else if (off < MMIO_SPAN)
         return REGION_MMIO;
      else
         return REGION_NONE;
   endfunction

endpackage

// File: rtl/mmio_timer.sv
// Interval timer: TH reload, TL up-counter, TCON control/status.
// CPU writes take priority over the timer update of the same register.
module mmio_timer
   import mmio_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we_th,
   input  logic        we_tl,
   input  logic        we_tcon,
   input  logic [31:0] wdata,
   output logic [31:0] th,
   output logic [31:0] tl,
   output logic [2:0]  tcon,
   output logic        irqout
);

   logic ovf;

   assign ovf    = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
   assign irqout = tcon[TCON_IE] & tcon[TCON_IS];

   // Register writes, counting, reload and status set on overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         th   <= '0;
         tl   <= '0;
         tcon <= '0;
      end else begin
         if (we_th)
            th <= wdata;

         if (we_tl)
            tl <= wdata;
         else if (tcon[TCON_EN])
            tl <= ovf ? th : tl + 32'd1;

         if (we_tcon)
            tcon <= wdata[2:0];
         else if (ovf && tcon[TCON_IE])
            tcon[TCON_IS] <= 1'b1;
      end
   end

endmodule

// File: rtl/data_mem_mmio.sv
// Data-side memory responder: word RAM plus timer/LED/switch/systick.
// Loads are combinational; stores commit on the rising clock edge.
module data_mem_mmio
   import mmio_pkg::*;
#(
   parameter int          RAM_WORDS = 256,
   parameter logic [31:0] MMIO_BASE = 32'h4000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] Address,
   input  logic [31:0] Write_data,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [7:0]  switch,
   output logic [31:0] Read_data,
   output logic        irqout,
   output logic [7:0]  led,
   output logic [31:0] systick
);

   localparam int          AW        = $clog2(RAM_WORDS);
   localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

   logic [31:0]   ram [RAM_WORDS];
   logic [AW-1:0] ram_idx;
   region_e       region;
   logic          is_ram;
   logic          is_mmio;
   logic [31:0]   mmio_off;
   logic [4:0]    reg_off;
   logic [31:0]   mmio_rd;
   logic [7:0]    sw_meta;
   logic [7:0]    sw_sync;
   logic [31:0]   th;
   logic [31:0]   tl;
   logic [2:0]    tcon;
   logic          we_th;
   logic          we_tl;
   logic          we_tcon;
   logic          unused_ok;

   assign region    = decode_region(Address, RAM_BYTES, MMIO_BASE);
   assign is_ram    = (region == REGION_RAM);
   assign is_mmio   = (region == REGION_MMIO);
   assign ram_idx   = Address[AW+1:2];
   assign mmio_off  = Address - MMIO_BASE;
   assign reg_off   = {mmio_off[4:2], 2'b00};
   assign unused_ok = ^{mmio_off[31:5], mmio_off[1:0]};

   assign we_th   = MemWrite && is_mmio && (reg_off == OFF_TH);
   assign we_tl   = MemWrite && is_mmio && (reg_off == OFF_TL);
   assign we_tcon = MemWrite && is_mmio && (reg_off == OFF_TCON);

   mmio_timer u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_th   (we_th),
      .we_tl   (we_tl),
      .we_tcon (we_tcon),
      .wdata   (Write_data),
      .th      (th),
      .tl      (tl),
      .tcon    (tcon),
      .irqout  (irqout)
   );

   // Data RAM store port; stores during reset are dropped
   always_ff @(posedge clk) begin
      if (rst_n && MemWrite && is_ram)
         ram[ram_idx] <= Write_data;
   end

   // LED register, switch synchronizer and free-running cycle counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led     <= '0;
         sw_meta <= '0;
         sw_sync <= '0;
         systick <= '0;
      end else begin
         if (MemWrite && is_mmio && (reg_off == OFF_LED))
            led <= Write_data[7:0];
         sw_meta <= switch;
         sw_sync <= sw_meta;
         systick <= systick + 32'd1;
      end
   end

   // Peripheral register readback
   always_comb begin
      mmio_rd = '0;
      case (reg_off)
         OFF_TH:      mmio_rd = th;
         OFF_TL:      mmio_rd = tl;
         OFF_TCON:    mmio_rd = {29'd0, tcon};
         OFF_LED:     mmio_rd = {24'd0, led};
         OFF_SWITCH:  mmio_rd = {24'd0, sw_sync};
         OFF_SYSTICK: mmio_rd = systick;
         default:     mmio_rd = '0;
      endcase
   end

   // Load data mux; zero when no load or unmapped address
   always_comb begin
      Read_data = '0;
      if (MemRead) begin
         unique case (1'b1)
            is_ram:  Read_data = ram[ram_idx];
            is_mmio: Read_data = mmio_rd;
            default: Read_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio.
// Randomized stimulus against a behavioural model of the memory map.
module tb_data_mem_mmio;

   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam logic [31:0] A_TH = BASE + 32'h00;
   localparam logic [31:0] A_TL = BASE + 32'h04;
   localparam logic [31:0] A_TC = BASE + 32'h08;
   localparam logic [31:0] A_LED = BASE + 32'h0C;
   localparam logic [31:0] A_SW = BASE + 32'h10;
   localparam logic [31:0] A_ST = BASE + 32'h14;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] Address;
   logic [31:0] Write_data;
   logic        MemRead;
   logic        MemWrite;
   logic [7:0]  sw;
   logic [31:0] Read_data;
   logic        irqout;
   logic [7:0]  led;
   logic [31:0] systick;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem_model [int];

   data_mem_mmio dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .Address    (Address),
      .Write_data (Write_data),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .switch     (sw),
      .Read_data  (Read_data),
      .irqout     (irqout),
      .led        (led),
      .systick    (systick)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      Address    = a;
      Write_data = d;
      MemWrite   = 1'b1;
      tick();
      MemWrite   = 1'b0;
   endtask

   task automatic load(input logic [31:0] a, output logic [31:0] d);
      Address = a;
      MemRead = 1'b1;
      #1;
      d       = Read_data;
      MemRead = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      checks++;
      if (systick !== 32'd0 || led !== 8'd0 || irqout !== 1'b0) begin
         errors++;
         $display("FAIL reset_outs got st=%h led=%h irq=%b want 0",
                  systick, led, irqout);
      end
      load(A_TH, d);
      checks++;
      if (d !== 32'd0) begin
         errors++; $display("FAIL reset_th got %h want 0", d);
      end
      load(A_TL, d);
      checks++;
      if (d !== 32'd0) begin
         errors++; $display("FAIL reset_tl got %h want 0", d);
      end
      load(A_TC, d);
      checks++;
      if (d !== 32'd0) begin
         errors++; $display("FAIL reset_tcon got %h want 0", d);
      end
      tick();
      checks++;
      if (systick !== 32'd1) begin
         errors++; $display("FAIL reset_tick got %h want 1", systick);
      end
   endtask

   task automatic test_ram();
      logic [31:0] d;
      logic [31:0] nv;
      int          idx;
      store(32'h10, 32'hDEAD_BEEF);
      mem_model[4] = 32'hDEAD_BEEF;
      load(32'h10, d);
      checks++;
      if (d !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL ram_rt got %h want deadbeef", d);
      end
      for (int i = 0; i < 24; i++) begin
         idx = int'($urandom_range(0, 255));
         nv  = $urandom;
         store(32'(idx * 4), nv);
         mem_model[idx] = nv;
      end
      foreach (mem_model[k]) begin
         load(32'(k * 4), d);
         checks++;
         if (d !== mem_model[k]) begin
            errors++;
            $display("FAIL ram_rand idx=%0d got %h want %h",
                     k, d, mem_model[k]);
         end
      end
      store(32'h30, 32'h1111_2222);
      mem_model[12] = 32'h1111_2222;
      nv         = $urandom;
      Address    = 32'h30;
      Write_data = nv;
      MemRead    = 1'b1;
      MemWrite   = 1'b1;
      #1;
      checks++;
      if (Read_data !== 32'h1111_2222) begin
         errors++;
         $display("FAIL ram_rw_old got %h want 11112222", Read_data);
      end
      tick();
      MemWrite = 1'b0;
      #1;
      mem_model[12] = nv;
      checks++;
      if (Read_data !== nv) begin
         errors++;
         $display("FAIL ram_rw_new got %h want %h", Read_data, nv);
      end
      MemRead = 1'b0;
   endtask

   task automatic test_decode();
      logic [31:0] d;
      store(32'h0, 32'h1111_1111);
      store(32'h400, 32'h2222_2222);
      load(32'h0, d);
      checks++;
      if (d !== 32'h1111_1111) begin
         errors++; $display("FAIL dec_ram_end got %h want 11111111", d);
      end
      store(A_SW, 32'hFF);
      load(A_SW, d);
      checks++;
      if (d !== 32'h0) begin
         errors++; $display("FAIL dec_sw_ro got %h want 0", d);
      end
      store(BASE + 32'h30, 32'h1234);
      load(BASE + 32'h30, d);
      checks++;
      if (d !== 32'h0) begin
         errors++; $display("FAIL dec_hole got %h want 0", d);
      end
      load(BASE + 32'h18, d);
      checks++;
      if (d !== 32'h0) begin
         errors++; $display("FAIL dec_past got %h want 0", d);
      end
      Address = 32'h0;
      MemRead = 1'b0;
      #1;
      checks++;
      if (Read_data !== 32'h0) begin
         errors++;
         $display("FAIL dec_noread got %h want 0", Read_data);
      end
   endtask

   task automatic arm(input logic [31:0] th, input logic [31:0] tl0);
      store(A_TC, 32'h0);
      store(A_TH, th);
      store(A_TL, tl0);
      store(A_TC, 32'h3);
   endtask

   task automatic test_timer();
      logic [31:0] d;
      logic [31:0] th;
      logic [31:0] tl0;
      longint      first;
      longint      period;
      int          n;
      int          k;
      for (int r = 0; r < 4; r++) begin
         if (r == 0) begin
            th  = 32'hFFFF_FFFC;
            tl0 = 32'hFFFF_FFFC;
         end else begin
            th  = 32'hFFFF_FFFF - $urandom_range(1, 15);
            tl0 = 32'hFFFF_FFFF - $urandom_range(0, 15);
         end
         first  = 64'h1_0000_0000 - longint'(tl0);
         period = 64'h1_0000_0000 - longint'(th);
         arm(th, tl0);
         n = 0;
         while (!irqout && n < 40) begin
            tick();
            n++;
         end
         checks++;
         if (longint'(n) != first) begin
            errors++;
            $display("FAIL tmr_first r=%0d got %0d want %0d",
                     r, n, first);
         end
         load(A_TL, d);
         checks++;
         if (d !== th) begin
            errors++;
            $display("FAIL tmr_reload r=%0d got %h want %h", r, d, th);
         end
         k = int'($urandom_range(1, 32'(period - 1)));
         repeat (k) tick();
         load(A_TL, d);
         checks++;
         if (d !== th + 32'(k)) begin
            errors++;
            $display("FAIL tmr_count r=%0d got %h want %h",
                     r, d, th + 32'(k));
         end
         repeat (int'(period) - k) tick();
         load(A_TL, d);
         checks++;
         if (d !== th || irqout !== 1'b1) begin
            errors++;
            $display("FAIL tmr_period r=%0d got tl=%h irq=%b want %h 1",
                     r, d, irqout, th);
         end
      end
   endtask

   task automatic test_ack_race();
      logic [31:0] d;
      int          n;
      arm(32'hFFFF_FFFC, 32'hFFFF_FFFC);
      repeat (3) tick();
      store(A_TC, 32'h3);
      load(A_TC, d);
      checks++;
      if (d !== 32'h3 || irqout !== 1'b0) begin
         errors++;
         $display("FAIL ack_race got tcon=%h irq=%b want 3 0", d, irqout);
      end
      load(A_TL, d);
      checks++;
      if (d !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL ack_reload got %h want fffffffc", d);
      end
      n = 0;
      while (!irqout && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (n != 4) begin
         errors++; $display("FAIL ack_rearm got %0d want 4", n);
      end
      repeat (3) tick();
      store(A_TL, 32'h5);
      load(A_TL, d);
      checks++;
      if (d !== 32'h5) begin
         errors++; $display("FAIL tl_race got %h want 5", d);
      end
   endtask

   task automatic test_led_switch_systick();
      logic [31:0] d;
      logic [31:0] a;
      logic [7:0]  prev;
      logic [7:0]  v;
      store(A_LED, 32'hA5);
      checks++;
      if (led !== 8'hA5) begin
         errors++; $display("FAIL led_out got %h want a5", led);
      end
      store(A_LED, 32'hFFFF_FF3C);
      load(A_LED, d);
      checks++;
      if (d !== 32'h3C) begin
         errors++; $display("FAIL led_read got %h want 3c", d);
      end
      prev = 8'h00;
      for (int i = 0; i < 3; i++) begin
         v  = (i == 0) ? 8'h3C : 8'($urandom);
         sw = v;
         tick();
         load(A_SW, d);
         checks++;
         if (d !== {24'd0, prev}) begin
            errors++;
            $display("FAIL sw_early got %h want %h", d, prev);
         end
         tick();
         load(A_SW, d);
         checks++;
         if (d !== {24'd0, v}) begin
            errors++; $display("FAIL sw_sync got %h want %h", d, v);
         end
         prev = v;
      end
      load(A_ST, a);
      checks++;
      if (a !== systick) begin
         errors++; $display("FAIL st_port got %h want %h", systick, a);
      end
      repeat (10) tick();
      load(A_ST, d);
      checks++;
      if (d - a !== 32'd10) begin
         errors++; $display("FAIL st_delta got %0d want 10", d - a);
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] d;
      int          n;
      store(32'h20, 32'hCAFE_0001);
      store(A_LED, 32'h5A);
      arm(32'hFFFF_FFFC, 32'hFFFF_FFFC);
      n = 0;
      while (!irqout && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (irqout !== 1'b1) begin
         errors++; $display("FAIL rst_pre got irq=%b want 1", irqout);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (irqout !== 1'b0 || led !== 8'd0 || systick !== 32'd0) begin
         errors++;
         $display("FAIL rst_async got irq=%b led=%h st=%h want 0",
                  irqout, led, systick);
      end
      Address    = 32'h20;
      Write_data = 32'hBAD0_BAD0;
      MemWrite   = 1'b1;
      tick();
      MemWrite = 1'b0;
      rst_n    = 1'b1;
      load(32'h20, d);
      checks++;
      if (d !== 32'hCAFE_0001) begin
         errors++; $display("FAIL rst_store got %h want cafe0001", d);
      end
      repeat (3) tick();
      load(A_TH, d);
      checks++;
      if (d !== 32'h0) begin
         errors++; $display("FAIL rst_th got %h want 0", d);
      end
      load(A_TL, d);
      checks++;
      if (d !== 32'h0) begin
         errors++; $display("FAIL rst_tl got %h want 0", d);
      end
      load(A_TC, d);
      checks++;
      if (d !== 32'h0) begin
         errors++; $display("FAIL rst_tcon got %h want 0", d);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      Address    = '0;
      Write_data = '0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      sw         = 8'h00;
      test_reset();
      test_ram();
      test_decode();
      test_timer();
      test_ack_race();
      test_led_switch_systick();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
